// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: one 32-step shift-add / restoring-divide datapath shared by all ops.
// Build option MULDIV_DIV_EN: when undefined, the divider is absent and DIV/DIVU/REM/REMU report illegal.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            CLK,
    input  logic            RST_X,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic            we,
    output logic [4:0]      rd_out,
    output logic [XLEN-1:0] result,
    output logic            illegal
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  acc_hi;
    logic [XLEN-1:0]  acc_lo;
    logic [XLEN-1:0]  opnd;
    logic [1:0]       op_r;
    logic             neg_a_r;
    logic             neg_b_r;
    logic             fast_r;

    function automatic logic [XLEN-1:0] apply_sign(input logic [XLEN-1:0] v, input logic neg);
        logic signed [XLEN-1:0] sv;
        sv = $signed(v);
        return neg ? -sv : sv;
    endfunction

    function automatic logic [2*XLEN-1:0] apply_sign_wide(input logic [2*XLEN-1:0] v, input logic neg);
        logic signed [2*XLEN-1:0] sv;
        sv = $signed(v);
        return neg ? -sv : sv;
    endfunction

    // Datapath holds magnitudes; the sign and the half/quotient/remainder selection happen once here.
    function automatic logic [XLEN-1:0] fix_value(input logic is_div, input logic [1:0] op,
                                                 input logic na, input logic nb,
                                                 input logic [XLEN-1:0] hi, input logic [XLEN-1:0] lo);
        logic [2*XLEN-1:0] prod;
        prod = apply_sign_wide({hi, lo}, na ^ nb);
        if (is_div)
            return op[1] ? apply_sign(hi, na) : apply_sign(lo, na ^ nb);
        return (op == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    endfunction

    logic            a_sgn;
    logic            b_sgn;
    logic            neg_a;
    logic            neg_b;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic            fast_sel;
    logic [XLEN:0]   mul_sum;

    assign a_sgn = !(funct3 == 3'd3 || funct3 == 3'd5 || funct3 == 3'd7);
    assign b_sgn = a_sgn && (funct3 != 3'd2);
    assign neg_a = a_sgn && rs1_val[XLEN-1];
    assign neg_b = b_sgn && rs2_val[XLEN-1];
    assign abs_a = apply_sign(rs1_val, neg_a);
    assign abs_b = apply_sign(rs2_val, neg_b);
    assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);

`ifdef MULDIV_DIV_EN
    logic          div_r;
    logic          div_by_zero;
    logic          div_ovf;
    logic [XLEN:0] rem_sh;
    logic [XLEN:0] rem_sub;
    logic          geq;
    localparam logic ill_fix = 1'b0;

    assign div_by_zero = (rs2_val == '0);
    assign div_ovf     = !funct3[0] && (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_val == '1);
    assign fast_sel    = funct3[2] && (div_by_zero || div_ovf);
    assign rem_sh      = {acc_hi, acc_lo[XLEN-1]};
    assign rem_sub     = rem_sh - {1'b0, opnd};
    // Remainder stays below the divisor, so bit XLEN of the difference is a clean borrow.
    assign geq         = !rem_sub[XLEN];
    assign illegal     = 1'b0;
`else
    localparam logic div_r = 1'b0;
    logic ill_fix;
    logic ill_q;

    assign fast_sel = funct3[2];
    assign ill_fix  = fast_r;
    assign illegal  = ill_q;

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) ill_q <= 1'b0;
        else        ill_q <= (state == FIX) && fast_r;
    end
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state  <= IDLE;
            cnt    <= '0;
            done   <= 1'b0;
            we     <= 1'b0;
            rd_out <= '0;
            result <= '0;
        end else begin
            done <= 1'b0;
            we   <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    rd_out <= rd_in;
                    cnt    <= '0;
                    state  <= fast_sel ? FIX : CALC;
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) state <= FIX;
                end
                FIX: begin
                    result <= fast_r ? acc_lo : fix_value(div_r, op_r, neg_a_r, neg_b_r, acc_hi, acc_lo);
                    done   <= 1'b1;
                    we     <= (rd_out != '0) && !ill_fix;
                    state  <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Operand/accumulator registers carry no reset: they are always loaded on accept before use.
    always_ff @(posedge CLK) begin
        case (state)
            IDLE: if (start) begin
                op_r    <= funct3[1:0];
                neg_a_r <= neg_a;
                neg_b_r <= neg_b;
                fast_r  <= fast_sel;
                acc_hi  <= '0;
`ifdef MULDIV_DIV_EN
                div_r   <= funct3[2];
                if (funct3[2]) begin
                    acc_lo <= abs_a;
                    opnd   <= abs_b;
                    if (div_by_zero)  acc_lo <= funct3[1] ? rs1_val : '1;
                    else if (div_ovf) acc_lo <= funct3[1] ? '0 : rs1_val;
                end else begin
                    acc_lo <= abs_b;
                    opnd   <= abs_a;
                end
`else
                acc_lo  <= funct3[2] ? '0 : abs_b;
                opnd    <= abs_a;
`endif
            end
            CALC: begin
`ifdef MULDIV_DIV_EN
                if (div_r) begin
                    acc_hi <= geq ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0];
                    acc_lo <= {acc_lo[XLEN-2:0], geq};
                end else
`endif
                begin
                    acc_hi <= mul_sum[XLEN:1];
                    acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
                end
            end
            default: ;
        endcase
    end

endmodule
